sdram_word_reader: RTL and testbench



---
 rtl/sdram_word_reader.sv | 82 ++++++++
 tb/tb_sdram_word_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_word_reader.sv
// Single-word Avalon-MM read engine: fetches one 16-bit word
// from the SDRAM controller for a simple requester.
module sdram_word_reader (
  input  logic        clock_50,
  input  logic        reset_50,
  input  logic [25:0] address_12,
  input  logic        request_12,
  output logic        done_12,
  output logic [15:0] readdata_12,
  output logic [25:0] sdram_addr,
  output logic [1:0]  sdram_byteenable_n,
  output logic        sdram_chipselect,
  output logic [15:0] sdram_writedata,
  output logic        sdram_read_n,
  output logic        sdram_write_n,
  input  logic [15:0] sdram_readdata,
  input  logic        sdram_readdata_valid,
  input  logic        sdram_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT_DATA,
    DONE
  } state_t;

  localparam logic [1:0]  BE_ALL   = 2'b00;
  localparam logic [15:0] WDATA_Z  = 16'h0000;

  state_t state;

  assign sdram_byteenable_n = BE_ALL;
  assign sdram_writedata    = WDATA_Z;
  assign sdram_write_n      = 1'b1;

  always_ff @(posedge clock_50 or negedge reset_50) begin
    if (!reset_50) begin
      state            <= IDLE;
      sdram_addr       <= '0;
      sdram_chipselect <= 1'b0;
      sdram_read_n     <= 1'b1;
      readdata_12      <= '0;
      done_12          <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (request_12) begin
            sdram_addr       <= address_12;
            done_12          <= 1'b0;
            sdram_chipselect <= 1'b1;
            sdram_read_n     <= 1'b0;
            state            <= READ;
          end
        end
        READ: begin
          // acceptance edge; data may ride along on the same beat
          if (!sdram_waitrequest) begin
            sdram_chipselect <= 1'b0;
            sdram_read_n     <= 1'b1;
            if (sdram_readdata_valid) begin
              readdata_12 <= sdram_readdata;
              done_12     <= 1'b1;
              state       <= DONE;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (sdram_readdata_valid) begin
            readdata_12 <= sdram_readdata;
            done_12     <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_word_reader.sv
// Bench for sdram_word_reader: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_sdram_word_reader;

  logic        clk;
  logic        rst_n;
  logic [25:0] addr;
  logic        req;
  logic        done;
  logic [15:0] rdata;
  logic [25:0] s_addr;
  logic [1:0]  s_be_n;
  logic        s_cs;
  logic [15:0] s_wdata;
  logic        s_rd_n;
  logic        s_wr_n;
  logic [15:0] s_rdata;
  logic        s_valid;
  logic        s_wait;

  int vectors = 0;
  int errors  = 0;
  int strobes = 0;
  int cs_cycles = 0;

  sdram_word_reader dut (
    .clock_50             (clk),
    .reset_50             (rst_n),
    .address_12           (addr),
    .request_12           (req),
    .done_12              (done),
    .readdata_12          (rdata),
    .sdram_addr           (s_addr),
    .sdram_byteenable_n   (s_be_n),
    .sdram_chipselect     (s_cs),
    .sdram_writedata      (s_wdata),
    .sdram_read_n         (s_rd_n),
    .sdram_write_n        (s_wr_n),
    .sdram_readdata       (s_rdata),
    .sdram_readdata_valid (s_valid),
    .sdram_waitrequest    (s_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a read is either outstanding on the bus
  // (strobed), accepted and awaiting data, or not in flight.
  logic        m_strobed;
  logic        m_awaiting;
  logic [25:0] m_addr;
  logic [15:0] m_data;
  logic        m_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_strobed  = 1'b0;
      m_awaiting = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      m_done     = 1'b0;
    end else if (m_strobed) begin
      if (!s_wait) begin
        m_strobed = 1'b0;
        if (s_valid) begin
          m_data = s_rdata;
          m_done = 1'b1;
        end else begin
          m_awaiting = 1'b1;
        end
      end
    end else if (m_awaiting) begin
      if (s_valid) begin
        m_data     = s_rdata;
        m_done     = 1'b1;
        m_awaiting = 1'b0;
      end
    end else if (req) begin
      m_addr    = addr;
      m_done    = 1'b0;
      m_strobed = 1'b1;
    end
    #1;
    chk("cs",      32'(s_cs),    32'(m_strobed));
    chk("read_n",  32'(s_rd_n),  32'(!m_strobed));
    chk("addr",    32'(s_addr),  32'(m_addr));
    chk("rdata",   32'(rdata),   32'(m_data));
    chk("done",    32'(done),    32'(m_done));
    chk("write_n", 32'(s_wr_n),  32'd1);
    chk("be_n",    32'(s_be_n),  32'd0);
    chk("wdata",   32'(s_wdata), 32'd0);
  end

  always @(posedge s_cs) strobes++;
  always @(posedge clk) if (s_cs === 1'b1) cs_cycles++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    addr    = '0;
    req     = 1'b0;
    s_rdata = '0;
    s_valid = 1'b0;
    s_wait  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs",     32'(s_cs),   32'd0);
    chk("rst_read_n", 32'(s_rd_n), 32'd1);
    chk("rst_addr",   32'(s_addr), 32'd0);
    chk("rst_rdata",  32'(rdata),  32'd0);
    chk("rst_done",   32'(done),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic read with 5 wait cycles, plus a busy request
    strobes = 0;
    addr = 26'hFF02; req = 1'b1; s_wait = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("basic_addr",   32'(s_addr), 32'hFF02);
      chk("basic_read_n", 32'(s_rd_n), 32'd0);
      @(negedge clk);
    end
    s_wait = 1'b0;
    @(negedge clk);
    chk("basic_cs_off", 32'(s_cs), 32'd0);
    req = 1'b1; addr = 26'h0001;
    @(negedge clk);
    req = 1'b0;
    s_valid = 1'b1; s_rdata = 16'h010F;
    chk("busy_addr", 32'(s_addr), 32'hFF02);
    chk("busy_cs",   32'(s_cs),   32'd0);
    @(negedge clk);
    s_valid = 1'b0; s_rdata = 16'h0000;
    chk("basic_rdata",   32'(rdata),   32'h010F);
    chk("basic_done",    32'(done),    32'd1);
    chk("busy_strobes",  32'(strobes), 32'd1);
    chk("busy_addr2",    32'(s_addr),  32'hFF02);
    repeat (2) @(negedge clk);

    // zero-wait read, data on the accept beat
    strobes = 0; cs_cycles = 0;
    addr = 26'h0123; req = 1'b1; s_wait = 1'b0;
    @(negedge clk);
    req = 1'b0;
    s_valid = 1'b1; s_rdata = 16'h5A5A;
    chk("zw_cs_on",  32'(s_cs), 32'd1);
    chk("zw_done_0", 32'(done), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("zw_done_1",  32'(done),      32'd1);
    chk("zw_rdata",   32'(rdata),     32'h5A5A);
    chk("zw_cs_off",  32'(s_cs),      32'd0);
    chk("zw_cs_len",  32'(cs_cycles), 32'd1);
    chk("zw_strobes", 32'(strobes),   32'd1);

    // back-to-back request from DONE
    addr = 26'h3FFFFFF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("b2b_done_drop", 32'(done),   32'd0);
    chk("b2b_addr",      32'(s_addr), 32'h3FFFFFF);
    chk("b2b_cs",        32'(s_cs),   32'd1);
    @(negedge clk);
    s_valid = 1'b1; s_rdata = 16'hBEEF;
    @(negedge clk);
    s_valid = 1'b0;
    chk("b2b_rdata", 32'(rdata), 32'hBEEF);
    chk("b2b_done",  32'(done),  32'd1);

    // reset while strobed
    addr = 26'h0055; req = 1'b1; s_wait = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("mid_cs_on", 32'(s_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cs",     32'(s_cs),   32'd0);
    chk("mid_read_n", 32'(s_rd_n), 32'd1);
    chk("mid_rdata",  32'(rdata),  32'd0);
    chk("mid_done",   32'(done),   32'd0);
    chk("mid_addr",   32'(s_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; s_wait = 1'b0;
    s_valid = 1'b1; s_rdata = 16'hDEAD;
    @(negedge clk);
    s_valid = 1'b0;
    chk("stray_done",  32'(done),  32'd0);
    chk("stray_rdata", 32'(rdata), 32'd0);
    chk("stray_cs",    32'(s_cs),  32'd0);

    // randomized traffic, including stray valids and busy requests
    for (int i = 0; i < 3000; i++) begin
      req     = ($urandom_range(0, 3) == 0);
      addr    = 26'($urandom);
      s_wait  = ($urandom_range(0, 2) == 0);
      s_valid = ($urandom_range(0, 3) == 0);
      s_rdata = 16'($urandom);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1; req = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
